// File: rtl/snake_frame_reader.sv
// Renders one 4x4 snake frame: streams body cells from a synchronous RAM,
// builds the lit-cell bitmap and reports apple/self collisions with a done pulse.
module snake_frame_reader (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [3:0]  size_i,
    input  logic [3:0]  apple_i,
    output logic [3:0]  ram_addr_o,
    input  logic [3:0]  ram_data_i,
    output logic        ram_rd_o,
    output logic [15:0] frame_o,
    output logic        apple_hit_o,
    output logic        self_hit_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t      state_q;
    logic [3:0]  size_q;
    logic [3:0]  apple_q;
    logic [3:0]  head_q;
    logic [15:0] bitmap_q;
    logic        pend_q;
    logic        vld_q;
    logic [3:0]  idx_q;
    logic [3:0]  ram_addr_q;
    logic        ram_rd_q;
    logic [15:0] frame_q;
    logic        apple_hit_q;
    logic        self_hit_q;
    logic        busy_q;
    logic        done_q;

    logic [15:0] data_oh;
    logic [15:0] apple_oh;
    logic [3:0]  head_d;
    logic [15:0] frame_d;
    logic        apple_hit_d;
    logic        self_hit_d;

    // In DRAIN the word on ram_data_i is the last segment; for size 1 it is also the head.
    always_comb begin
        data_oh     = 16'd1 << ram_data_i;
        apple_oh    = 16'd1 << apple_q;
        head_d      = (idx_q == 4'd0) ? ram_data_i : head_q;
        self_hit_d  = pend_q | ((idx_q != 4'd0) && (ram_data_i == head_q));
        frame_d     = bitmap_q | data_oh | apple_oh;
        apple_hit_d = (head_d == apple_q);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            size_q      <= '0;
            apple_q     <= '0;
            head_q      <= '0;
            bitmap_q    <= '0;
            pend_q      <= 1'b0;
            vld_q       <= 1'b0;
            idx_q       <= '0;
            ram_addr_q  <= '0;
            ram_rd_q    <= 1'b0;
            frame_q     <= '0;
            apple_hit_q <= 1'b0;
            self_hit_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // RAM data lags the registered address by one cycle.
            vld_q  <= ram_rd_q;
            idx_q  <= ram_addr_q;
            if (vld_q) begin
                bitmap_q <= bitmap_q | data_oh;
                if (idx_q == 4'd0)
                    head_q <= ram_data_i;
                else if (ram_data_i == head_q)
                    pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        size_q     <= size_i;
                        apple_q    <= apple_i;
                        bitmap_q   <= '0;
                        head_q     <= '0;
                        pend_q     <= 1'b0;
                        ram_addr_q <= '0;
                        busy_q     <= 1'b1;
                        if (size_i != 4'd0) begin
                            state_q  <= READ;
                            ram_rd_q <= 1'b1;
                        end else begin
                            state_q  <= DONE;
                        end
                    end
                end
                READ: begin
                    if (ram_addr_q == size_q - 4'd1)
                        state_q <= DRAIN;
                    else
                        ram_addr_q <= ram_addr_q + 4'd1;
                end
                DRAIN: begin
                    state_q     <= DONE;
                    ram_rd_q    <= 1'b0;
                    ram_addr_q  <= '0;
                    frame_q     <= frame_d;
                    apple_hit_q <= apple_hit_d;
                    self_hit_q  <= self_hit_d;
                    done_q      <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    // Empty snake: the frame is published on the way out of DONE.
                    if (size_q == 4'd0) begin
                        frame_q     <= apple_oh;
                        apple_hit_q <= 1'b0;
                        self_hit_q  <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_addr_o  = ram_addr_q;
    assign ram_rd_o    = ram_rd_q;
    assign frame_o     = frame_q;
    assign apple_hit_o = apple_hit_q;
    assign self_hit_o  = self_hit_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_snake_frame_reader.sv
// Scoreboard bench for snake_frame_reader: directed board cases plus random renders
// checked against a set-based frame model, with a behavioural synchronous RAM.
module tb_snake_frame_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  size = '0;
    logic [3:0]  apple = '0;
    logic [3:0]  ram_addr;
    logic [3:0]  ram_data = '0;
    logic        ram_rd;
    logic [15:0] frame;
    logic        apple_hit;
    logic        self_hit;
    logic        busy;
    logic        done;

    logic [3:0] mem [16];

    typedef struct {
        logic [15:0] frame;
        logic        ah;
        logic        sh;
        int          size;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    snake_frame_reader dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .start_i     (start),
        .size_i      (size),
        .apple_i     (apple),
        .ram_addr_o  (ram_addr),
        .ram_data_i  (ram_data),
        .ram_rd_o    (ram_rd),
        .frame_o     (frame),
        .apple_hit_o (apple_hit),
        .self_hit_o  (self_hit),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        ram_data <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: address sequencing every cycle, results on each done pulse.
    logic       prev_rd = 1'b0;
    logic [3:0] prev_addr = '0;
    int         rd_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        int   ea;
        if (rst) begin
            prev_rd = 1'b0;
            rd_cnt  = 0;
        end else begin
            if (!ram_rd) check("addr_idle_zero", {28'd0, ram_addr}, 32'd0);
            if (ram_rd) begin
                if (sb.size() == 0) begin
                    check("rd_without_render", {31'd0, ram_rd}, 32'd0);
                end else begin
                    if (!prev_rd) ea = 0;
                    else ea = (int'(prev_addr) + 1 > sb[0].size - 1) ? sb[0].size - 1 : int'(prev_addr) + 1;
                    check("ram_addr_seq", {28'd0, ram_addr}, ea);
                end
                rd_cnt++;
            end
            prev_rd   = ram_rd;
            prev_addr = ram_addr;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("frame", {16'd0, frame}, {16'd0, e.frame});
                    check("apple_hit", {31'd0, apple_hit}, {31'd0, e.ah});
                    check("self_hit", {31'd0, self_hit}, {31'd0, e.sh});
                    check("done_latency", cyc, e.done_cyc);
                    check("rd_cycles", rd_cnt, (e.size != 0) ? e.size + 1 : 0);
                end
                rd_cnt = 0;
            end
        end
    end

    // Frame as a set of lit cells: every body cell plus the apple.
    function automatic exp_t model(input int sz, input logic [3:0] ap);
        exp_t e;
        e.frame = 16'd0;
        e.frame[ap] = 1'b1;
        for (int i = 0; i < sz; i++) e.frame[mem[i]] = 1'b1;
        e.ah = (sz > 0) && (mem[0] == ap);
        e.sh = 1'b0;
        for (int i = 1; i < sz; i++) if (mem[i] == mem[0]) e.sh = 1'b1;
        e.size = sz;
        e.done_cyc = 0;
        return e;
    endfunction

    // Called at posedge+2; the following posedge is edge T.
    task automatic issue(input int sz, input logic [3:0] ap, input exp_t e);
        exp_t x;
        x = e;
        x.size = sz;
        x.done_cyc = cyc + 1 + ((sz != 0) ? sz + 1 : 1);
        size  = 4'(sz);
        apple = ap;
        start = 1'b1;
        sb.push_back(x);
        @(posedge clk); #2;
        start = 1'b0;
        size  = 4'($urandom_range(0, 15));
        apple = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (!busy && !done && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL wait_idle: got busy=%0b pending=%0d expected idle", busy, sb.size());
            sb.delete();
        end
    endtask

    task automatic directed(input int sz, input logic [3:0] ap, input logic [15:0] fr,
                            input logic ah, input logic sh);
        exp_t e;
        e.frame = fr; e.ah = ah; e.sh = sh; e.size = sz; e.done_cyc = 0;
        issue(sz, ap, e);
        wait_idle();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_frame"}, {16'd0, frame}, 32'd0);
        check({name, "_flags"}, {27'd0, apple_hit, self_hit, busy, done, ram_rd}, 32'd0);
        check({name, "_addr"}, {28'd0, ram_addr}, 32'd0);
    endtask

    initial begin
        bit ok;
        int sz;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("reset_idle");
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            check_all_zero("idle_hold");
        end

        mem[0] = 4'd5; mem[1] = 4'd4; mem[2] = 4'd0; mem[3] = 4'd5;
        directed(3, 4'd10, 16'h0431, 1'b0, 1'b0);
        directed(1, 4'd5,  16'h0020, 1'b1, 1'b0);
        directed(4, 4'd15, 16'h8031, 1'b0, 1'b1);
        directed(0, 4'd3,  16'h0008, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) mem[i] = 4'(i);
        directed(15, 4'd15, 16'hFFFF, 1'b0, 1'b0);
        directed(15, 4'd0,  16'h7FFF, 1'b1, 1'b0);

        // Start re-pulsed while busy must be ignored.
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
        issue(6, 4'd9, model(6, 4'd9));
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_idle();

        // A start pulse in the DONE cycle is lost.
        issue(2, 4'd1, model(2, 4'd1));
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (done) begin ok = 1'b1; break; end
        end
        check("done_seen", {31'd0, ok}, 32'd1);
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_idle();
        repeat (3) begin
            @(posedge clk); #2;
            check("start_in_done_lost", {31'd0, busy}, 32'd0);
        end

        // Reset mid-render while ram_addr = 1.
        issue(8, 4'd2, model(8, 4'd2));
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ram_addr == 4'd1) begin ok = 1'b1; break; end
            @(posedge clk); #2;
        end
        check("addr1_seen", {31'd0, ok}, 32'd1);
        #1 rst = 1'b1;
        #1 check_all_zero("reset_mid_render");
        sb.delete();
        @(posedge clk); #2 rst = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        check("no_done_after_reset", {31'd0, busy}, 32'd0);

        for (int n = 0; n < 250; n++) begin
            for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) mem[$urandom_range(1, 14)] = mem[0];
            sz = $urandom_range(0, 15);
            begin
                logic [3:0] ap;
                ap = ($urandom_range(0, 3) == 0) ? mem[0] : 4'($urandom_range(0, 15));
                issue(sz, ap, model(sz, ap));
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snake_frame_reader.md
SNAKE_FRAME_READER -- requirements
Module: snake_frame_reader

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): none; all widths are fixed for the 4x4 board (cell = {row[3:2], col[1:0]}).
REQ-002 The block SHALL have this port: clock  in  1  single clock; all registers update on its rising edge.
REQ-003 The block SHALL have this port: reset  in  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 The block SHALL have this port: start  in  1  request to render one frame; sampled only in IDLE.
REQ-005 The block SHALL have this port: size  in  4  number of body segments held in RAM at addresses 0..size-1; address 0 is the head.
REQ-006 The block SHALL have this port: apple  in  4  apple cell.
REQ-007 The block SHALL have this port: ram_addr  out  4  read address driven to the 16x4 synchronous body RAM.
REQ-008 The block SHALL have this port: ram_data  in  4  RAM read data, valid the cycle after the edge that registered ram_addr.
REQ-009 The block SHALL have this port: ram_rd  out  1  high while the block owns the RAM address bus (READ and DRAIN).
REQ-010 The block SHALL have this port: frame  out  16  bit i = cell i lit (snake or apple); held between renders.
REQ-011 The block SHALL have this port: apple_hit  out  1  head cell equals apple cell; held with frame.
REQ-012 The block SHALL have this port: self_hit  out  1  some segment 1..size-1 equals head cell; held with frame.
REQ-013 The block SHALL have this port: busy  out  1  high in every state except IDLE.
REQ-014 The block SHALL have this port: done  out  1  one-cycle pulse; frame and flags are valid from this cycle.

Function
REQ-015 The FSM SHALL have the states IDLE, READ, DRAIN and DONE.
REQ-016 In IDLE with start=1 at edge T, the block SHALL capture size and apple into internal registers, clear the work bitmap and head register, and set ram_addr=0.
REQ-017 At edge T the next state SHALL be READ if the captured size is nonzero, else DONE.
REQ-018 Changes to size or apple after edge T SHALL have no effect until the next render.
REQ-019 In READ, ram_addr SHALL increment by 1 each edge; when ram_addr = size-1, the next state SHALL be DRAIN.
REQ-020 Each cycle in which ram_data is valid for address k, the block SHALL OR the one-hot of ram_data into the work bitmap at the next edge.
REQ-021 For k=0, the block SHALL store ram_data as the head; for k>=1, it SHALL set a pending self-hit when ram_data equals the head.
REQ-022 From DRAIN, the next state SHALL be DONE; at that same edge the block SHALL load frame from the work bitmap ORed with the final segment one-hot and the apple one-hot.
REQ-023 At the same edge, the block SHALL load apple_hit with (head == apple) and self_hit with the accumulated self-hit, then raise done.
REQ-024 If size=0, at edge T+1 the block SHALL load frame with the apple one-hot only, clear apple_hit and self_hit, and raise done; ram_rd SHALL never assert.
REQ-025 Latency SHALL be: done high in the cycle following edge T+size+1 (size>=1), or following edge T+1 (size=0).
REQ-026 From DONE, the next state SHALL be IDLE unconditionally; done SHALL be high for exactly one cycle.
REQ-027 start SHALL be ignored outside IDLE, and a start pulse in the DONE cycle SHALL be lost.
REQ-028 Duplicate cells SHALL light their bit once; an apple on a body cell SHALL not change frame beyond that bit.
REQ-029 The maximum size SHALL be 15 (addresses 0..14); the address SHALL NOT wrap.
REQ-030 ram_addr SHALL be 0 whenever ram_rd=0.

Reset
REQ-031 On reset=1, the block SHALL enter IDLE asynchronously and set frame=0, apple_hit=0, self_hit=0, done=0, busy=0, ram_rd=0, ram_addr=0, and clear all internal registers, including during a render.
REQ-032 After reset deasserts, the next render SHALL behave as if no render had been in progress.

Verification
REQ-033 Bench: assert reset mid-idle -> all outputs 0; release, hold start=0 for 10 cycles -> outputs stay 0, busy=0.
REQ-034 Bench: RAM {5,4,0}, size=3, apple=10, start at edge T -> ram_addr 0,1,2; done after edge T+4; frame=0x0431, apple_hit=0, self_hit=0.
REQ-035 Bench: RAM {5}, size=1, apple=5 -> frame=0x0020, apple_hit=1, self_hit=0, done after edge T+2.
REQ-036 Bench: RAM {5,4,0,5}, size=4, apple=15 -> frame=0x8031, self_hit=1, apple_hit=0.
REQ-037 Bench: size=0, apple=3 -> frame=0x0008, done after edge T+1, ram_rd never high.
REQ-038 Bench: start re-pulsed while busy -> ignored, single done; a second case asserts reset while ram_addr=1 -> immediate IDLE, frame=0, no done.
